// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared state encoding, width helpers and defaults for the TDC measurement engine
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ZERO = 2'd1,
        ST_WAIT_HIT  = 2'd2,
        ST_DONE      = 2'd3
    } tdc_state_e;

    localparam int DEF_N_DELAY = 256;
    localparam int DEF_AVG_MAX = 4;
    localparam int DEF_TO_W    = 8;

    function automatic int tdc_fw(input int n_delay);
        return $clog2(n_delay + 1);
    endfunction

    function automatic int tdc_aw(input int n_delay, input int avg_max);
        return $clog2(n_delay + 1) + avg_max;
    endfunction

endpackage

// File: rtl/tdc_popcount.sv
// rtl/tdc_popcount.sv - registered popcount of the thermometer word (bubble-tolerant fine code)
module tdc_popcount
    import tdc_pkg::*;
#(
    parameter  int N_DELAY = DEF_N_DELAY,
    localparam int FW      = tdc_fw(N_DELAY)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DELAY-1:0] therm,
    output logic [FW-1:0]      pc_q
);

    localparam int LG = (N_DELAY > 1) ? $clog2(N_DELAY) : 0;
    localparam int L  = 1 << LG;

    logic [L-1:0]  leaves;
    logic [FW-1:0] tree [LG+1][L];
    logic [FW-1:0] pc_d;

    assign leaves = L'(therm);

    // Pairwise reduction: level l holds L>>l partial sums, root ends up in tree[LG][0].
    always_comb begin
        tree = '{default: '0};
        for (int i = 0; i < L; i++) begin
            tree[0][i] = FW'(leaves[i]);
        end
        for (int l = 1; l <= LG; l++) begin
            for (int i = 0; i < (L >> l); i++) begin
                tree[l][i] = tree[l-1][2*i] + tree[l-1][2*i+1];
            end
        end
        pc_d = tree[LG][0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/tdc_meas_engine.sv
// rtl/tdc_meas_engine.sv - single-shot / averaged TDC measurement sequencer with timeout and result handshake
module tdc_meas_engine
    import tdc_pkg::*;
#(
    parameter  int N_DELAY = DEF_N_DELAY,
    parameter  int AVG_MAX = DEF_AVG_MAX,
    parameter  int TO_W    = DEF_TO_W,
    localparam int FW      = tdc_fw(N_DELAY),
    localparam int AW      = tdc_aw(N_DELAY, AVG_MAX),
    localparam int KW      = $clog2(AVG_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DELAY-1:0] i_therm,
    input  logic               i_arm,
    input  logic [KW-1:0]      i_avg_log2,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_valid,
    output logic [FW-1:0]      o_mean,
    output logic [AW-1:0]      o_acc,
    output logic               o_sat,
    output logic               o_timeout
);

    localparam int HW = AVG_MAX + 1;
    // Counter value seen on the last of the 2^TO_W-1 permitted wait cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((1 << TO_W) - 2);

    tdc_state_e      state, state_nx;
    logic [FW-1:0]   pc_q;
    logic [KW-1:0]   k_q, k_arm;
    logic [AW-1:0]   acc_q;
    logic [HW-1:0]   hit_cnt, hit_target;
    logic [TO_W-1:0] to_cnt;
    logic            sat_q, timeout_q;
    logic            hit, last_hit, to_expire, to_fire, waiting;

    tdc_popcount #(.N_DELAY(N_DELAY)) u_popcount (
        .clk   (clk),
        .rst_n (rst_n),
        .therm (i_therm),
        .pc_q  (pc_q)
    );

    assign k_arm      = (i_avg_log2 > KW'(AVG_MAX)) ? KW'(AVG_MAX) : i_avg_log2;
    assign hit_target = HW'(1) << k_q;
    assign waiting    = (state == ST_WAIT_ZERO) || (state == ST_WAIT_HIT);
    assign hit        = (state == ST_WAIT_HIT) && (pc_q != '0);
    assign last_hit   = (hit_cnt + HW'(1)) == hit_target;
    assign to_expire  = (to_cnt == TO_LAST);
    // A hit (or the line clearing) in the expiring cycle wins over the timeout.
    assign to_fire    = to_expire && waiting && !hit &&
                        !((state == ST_WAIT_ZERO) && (pc_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (i_arm) state_nx = ST_WAIT_ZERO;
            end
            ST_WAIT_ZERO: begin
                if (pc_q == '0)   state_nx = ST_WAIT_HIT;
                else if (to_fire) state_nx = ST_DONE;
            end
            ST_WAIT_HIT: begin
                if (hit)          state_nx = last_hit ? ST_DONE : ST_WAIT_ZERO;
                else if (to_fire) state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = 1'b1;
        o_valid = 1'b0;
        case (state)
            ST_IDLE: o_busy  = 1'b0;
            ST_DONE: o_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q       <= '0;
            acc_q     <= '0;
            hit_cnt   <= '0;
            to_cnt    <= '0;
            sat_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if ((state == ST_IDLE) && i_arm) begin
            k_q       <= k_arm;
            acc_q     <= '0;
            hit_cnt   <= '0;
            to_cnt    <= '0;
            sat_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (hit) begin
                acc_q   <= acc_q + AW'(pc_q);
                hit_cnt <= hit_cnt + HW'(1);
                if (pc_q == FW'(N_DELAY)) sat_q <= 1'b1;
            end
            if (to_fire) timeout_q <= 1'b1;
            if (state_nx != state) begin
                to_cnt <= '0;
            end else if (waiting) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    assign o_acc     = acc_q;
    assign o_mean    = timeout_q ? '0 : FW'(acc_q >> k_q);
    assign o_sat     = sat_q;
    assign o_timeout = timeout_q;

endmodule
